mul_share_arbiter: RTL and testbench

//  Shares one combinational 8x8 unsigned multiplier among NREQ requesters.

---
 rtl/mul_share_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one external combinational 8x8 unsigned multiplier among NREQ
//   requesters. A round-robin arbiter grants one request at a time through a
//   valid/ready handshake. The granted operands are registered onto mul_a and
//   mul_b. After SETTLE cycles the product mul_p is captured and returned on a
//   single response channel, tagged with the requester id.
//
// Parameters
//   NREQ    number of requesters (2..16)
//   SETTLE  cycles the registered operands are held before mul_p is sampled (1..15)
//   IDW     requester id width, derived from NREQ
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid[NREQ]     per-requester request valid
//   req_a/req_b         operands, requester i on bits [8i+7:8i]
//   req_ready[NREQ]     one-hot grant, high only in IDLE
//   mul_a/mul_b         registered operands driven to the shared multiplier
//   mul_p               product returned by the multiplier
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_prod     requester id and full 16-bit product of the response
//
// Optional build macro
//   MUL_ARB_STATS_EN    adds the saturating counters stat_ops (completed
//                       responses) and stat_stall (cycles with
//                       rsp_valid & !rsp_ready)
module mul_share_arbiter #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 1,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [15:0]          mul_p,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_prod,
    input  logic                 rsp_ready
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [15:0]          stat_ops,
    output logic [15:0]          stat_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] grant_id;
    logic           grant_found;
    logic [7:0]     sel_a;
    logic [7:0]     sel_b;
    logic [3:0]     cnt;
    logic           grant_fire;
    logic           sample_fire;
    logic           rsp_done;

    // Round-robin search in two passes: first the requesters at or above
    // rr_ptr, then (only if none of those is valid) the lowest valid index,
    // which is exactly the wrap-around continuation of the search.
    always_comb begin : arb_search
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_id    = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(i);
            end
        end
    end

    always_comb begin : operand_mux
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_a = req_a[8*i +: 8];
                sel_b = req_b[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // req_ready is gated by rst so no grant is ever visible while reset is held.
    always_comb begin : fsm_next
        state_next  = state;
        req_ready   = '0;
        grant_fire  = 1'b0;
        sample_fire = 1'b0;
        rsp_done    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && grant_found) begin
                    grant_fire = 1'b1;
                    req_ready  = NREQ'(1) << grant_id;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    sample_fire = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            cur_id    <= '0;
            cnt       <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
        end else begin
            if (grant_fire) begin
                mul_a  <= sel_a;
                mul_b  <= sel_b;
                cur_id <= grant_id;
                cnt    <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            if (sample_fire) begin
                rsp_prod  <= mul_p;
                rsp_valid <= 1'b1;
                rsp_id    <= cur_id;
            end

            if (rsp_done) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
            end
        end
    end

`ifdef MUL_ARB_STATS_EN
    always_ff @(posedge clk) begin : stats
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (stat_ops != '1)) begin
                stat_ops <= stat_ops + 1'b1;
            end
            if (rsp_valid && !rsp_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//   Directed self-checking bench for mul_share_arbiter. Instance "dut" uses
//   SETTLE=1, instance "dut4" uses SETTLE=4 for the reset-during-WAIT case.
//   The shared multiplier is modelled as a plain combinational product.
//   Stat counters are checked when MUL_ARB_STATS_EN is defined.
module tb_mul_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // SETTLE=1 instance signals
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_prod;
    logic        rsp_ready;

    // SETTLE=4 instance signals
    logic        rst4;
    logic [3:0]  req_valid4;
    logic [31:0] req_a4;
    logic [31:0] req_b4;
    logic [3:0]  req_ready4;
    logic [7:0]  mul_a4;
    logic [7:0]  mul_b4;
    logic [15:0] mul_p4;
    logic        rsp_valid4;
    logic [1:0]  rsp_id4;
    logic [15:0] rsp_prod4;
    logic        rsp_ready4;

`ifdef MUL_ARB_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_stall;
    logic [15:0] stat_ops4;
    logic [15:0] stat_stall4;
`endif

    assign mul_p  = {8'h00, mul_a}  * {8'h00, mul_b};
    assign mul_p4 = {8'h00, mul_a4} * {8'h00, mul_b4};

    mul_share_arbiter #(.NREQ(4), .SETTLE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .rsp_ready (rsp_ready)
`ifdef MUL_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_stall(stat_stall)
`endif
    );

    mul_share_arbiter #(.NREQ(4), .SETTLE(4)) dut4 (
        .clk       (clk),
        .rst       (rst4),
        .req_valid (req_valid4),
        .req_a     (req_a4),
        .req_b     (req_b4),
        .req_ready (req_ready4),
        .mul_a     (mul_a4),
        .mul_b     (mul_b4),
        .mul_p     (mul_p4),
        .rsp_valid (rsp_valid4),
        .rsp_id    (rsp_id4),
        .rsp_prod  (rsp_prod4),
        .rsp_ready (rsp_ready4)
`ifdef MUL_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops4),
        .stat_stall(stat_stall4)
`endif
    );

    // Hand-computed round-robin expectations: a_i = i+3, b_i = 10.
    int          rr_id   [5] = '{0, 1, 2, 3, 0};
    logic [15:0] rr_prod [5] = '{16'd30, 16'd40, 16'd50, 16'd60, 16'd30};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the SETTLE=1 instance with rsp_ready held high:
    // grant visible in IDLE, one WAIT cycle, response, back to IDLE.
    task automatic txn(input logic [3:0] rv_in, input int gid,
                       input logic [15:0] prod, input string tag);
        req_valid = rv_in;
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'(1) << gid);
        @(posedge clk); #1;
        req_valid = rv_in & ~(4'b0001 << gid);
        chk({tag, "_wait_ready"}, 32'(req_ready), 0);
        chk({tag, "_wait_valid"}, 32'(rsp_valid), 0);
        @(posedge clk); #1;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
        chk({tag, "_rsp_id"},    32'(rsp_id),    gid);
        chk({tag, "_rsp_prod"},  32'(rsp_prod),  32'(prod));
        @(posedge clk); #1;
        chk({tag, "_rsp_done"},  32'(rsp_valid), 0);
    endtask

    initial begin : stimulus
        logic seen;

        rst        = 1'b1;
        req_valid  = 4'hF;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        rst4       = 1'b1;
        req_valid4 = '0;
        req_a4     = '0;
        req_b4     = '0;
        rsp_ready4 = 1'b1;

        // Reset held two cycles with every request valid
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_mul_a",     32'(mul_a),     0);
            chk("rst_mul_b",     32'(mul_b),     0);
            chk("rst_rsp_prod",  32'(rsp_prod),  0);
        end
`ifdef MUL_ARB_STATS_EN
        chk("rst_stat_ops",   32'(stat_ops),   0);
        chk("rst_stat_stall", 32'(stat_stall), 0);
`endif
        req_valid = '0;
        rst       = 1'b0;
        @(posedge clk); #1;

        // Single request, full-scale operands
        req_a[23:16] = 8'hFF;
        req_b[23:16] = 8'hFF;
        txn(4'b0100, 2, 16'hFE01, "single");

        // Fresh reset so the pointer starts at 0 for the fairness run
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            req_a[8*k +: 8] = 8'(k + 3);
            req_b[8*k +: 8] = 8'd10;
        end
        for (int j = 0; j < 5; j++) begin
            txn(4'hF, rr_id[j], rr_prod[j], "rr");
        end

        // Backpressure: pointer is 1, only requester 3 asks; 0x12*0x34 = 0x03A8
        req_a[31:24] = 8'h12;
        req_b[31:24] = 8'h34;
        rsp_ready    = 1'b0;
        req_valid    = 4'b1000;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        @(posedge clk); #1;
        for (int s = 0; s < 5; s++) begin
            chk("bp_no_grant", 32'(req_ready), 0);
            chk("bp_valid",    32'(rsp_valid), 1);
            chk("bp_id",       32'(rsp_id),    3);
            chk("bp_prod",     32'(rsp_prod),  32'h03A8);
            @(posedge clk); #1;
        end
`ifdef MUL_ARB_STATS_EN
        chk("bp_stat_stall", 32'(stat_stall), 5);
        chk("bp_stat_ops_held", 32'(stat_ops), 5);
`endif
        chk("bp_still_valid", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", 32'(rsp_valid), 0);
`ifdef MUL_ARB_STATS_EN
        chk("bp_stat_ops", 32'(stat_ops), 6);
        chk("bp_stat_stall_final", 32'(stat_stall), 5);
`endif
        req_valid = '0;

        // Wrap and skip with zero operands
        req_a = '0;
        req_b = '0;
        txn(4'b0100, 2, 16'h0000, "to_ptr3");
        txn(4'b1001, 3, 16'h0000, "wrap3");
        txn(4'b0001, 0, 16'h0000, "wrap0");
        txn(4'b0010, 1, 16'h0000, "skip1");

        // Pointer is 2: requester 2 drops before its grant edge, 1 wins by wrap
        req_valid = 4'b0110;
        #1;
        chk("drop_pre", 32'(req_ready), 32'h4);
        req_valid = 4'b0010;
        #1;
        chk("drop_post", 32'(req_ready), 32'h2);
        txn(4'b0010, 1, 16'h0000, "drop_txn");

        // SETTLE=4 instance: reset two cycles after the grant edge
        rst4         = 1'b0;
        req_a4[7:0]  = 8'd5;
        req_b4[7:0]  = 8'd7;
        req_valid4   = 4'b0001;
        #1;
        chk("s4_grant", 32'(req_ready4), 32'h1);
        @(posedge clk); #1;
        req_valid4 = '0;
        chk("s4_mul_a", 32'(mul_a4), 5);
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        chk("s4_rst_valid", 32'(rsp_valid4), 0);
        chk("s4_rst_mul_a", 32'(mul_a4),     0);
        chk("s4_rst_mul_b", 32'(mul_b4),     0);
        rst4 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (rsp_valid4) seen = 1'b1;
        end
        chk("s4_no_rsp", 32'(seen), 0);

        // New traffic after reset: id 0 wins first, latency SETTLE+1
        req_a4     = {8'd9, 8'd9, 8'd9, 8'd5};
        req_b4     = {8'd9, 8'd9, 8'd9, 8'd7};
        req_valid4 = 4'hF;
        #1;
        chk("s4_post_grant", 32'(req_ready4), 32'h1);
        @(posedge clk); #1;
        req_valid4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("s4_not_yet", 32'(rsp_valid4), 0);
        @(posedge clk); #1;
        chk("s4_rsp_valid", 32'(rsp_valid4), 1);
        chk("s4_rsp_id",    32'(rsp_id4),    0);
        chk("s4_rsp_prod",  32'(rsp_prod4),  35);
        @(posedge clk); #1;
        chk("s4_rsp_done",  32'(rsp_valid4), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
